// File: rtl/dcache_ctrl.sv
// dcache_ctrl -- direct-mapped, write-through, no-write-allocate data cache
// controller with one 64-bit word per line.
//
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   dcache_en         : one-cycle request strobe (accepted only when idle)
//   dcache_wren       : write request, qualified by dcache_en
//   dcache_flush      : flush (invalidate) request, qualified by dcache_en
//   dcache_addr       : byte address, bits [2:0] ignored
//   dcache_wdata      : store data
//   dcache_rdata      : registered load data, held until the next read completes
//   dcache_done       : one-cycle completion pulse per accepted request
//   mem_req/mem_wr    : level-held memory request, write when mem_wr=1
//   mem_addr/mem_wdata: 8-byte-aligned memory address and store data
//   mem_ack/mem_rdata : one-cycle memory completion and load data
//   hit_count/miss_count : saturating statistics counters
module dcache_ctrl #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dcache_en,
    input  logic        dcache_wren,
    input  logic        dcache_flush,
    input  logic [63:0] dcache_addr,
    input  logic [63:0] dcache_wdata,
    output logic [63:0] dcache_rdata,
    output logic        dcache_done,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int TAG_BITS = 61 - IDX_BITS;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, WRITE} state_t;

    state_t             state_q, state_d;
    logic [60:0]        reqLine_q, reqLine_d;
    logic [63:0]        reqWdata_q, reqWdata_d;
    logic               opWrite_q, opWrite_d;
    logic               opFlush_q, opFlush_d;
    logic               wasHit_q, wasHit_d;
    logic [63:0]        rdata_q, rdata_d;
    logic               done_q, done_d;
    logic               memReq_q, memReq_d;
    logic               memWr_q, memWr_d;
    logic [63:0]        memAddr_q, memAddr_d;
    logic [63:0]        memWdata_q, memWdata_d;
    logic [31:0]        hitCount_q, hitCount_d;
    logic [31:0]        missCount_q, missCount_d;
    logic [LINES-1:0]   valid_q, valid_d;

    logic [TAG_BITS-1:0] tagMem [LINES];
    logic [63:0]         dataMem [LINES];

    logic [IDX_BITS-1:0] lineIdx;
    logic [TAG_BITS-1:0] lineTag;
    logic                lookupHit;
    logic                lineWr;
    logic [63:0]         lineWrData;
    logic                unusedAddrBits;

    // The byte offset within a word never matters to a word-wide cache.
    assign unusedAddrBits = ^dcache_addr[2:0];

    // Index and tag come from the latched request, so the lookup is
    // unaffected by whatever the requester drives after the strobe.
    assign lineIdx   = reqLine_q[IDX_BITS-1:0];
    assign lineTag   = reqLine_q[60:IDX_BITS];
    assign lookupHit = valid_q[lineIdx] && (tagMem[lineIdx] == lineTag);

    function automatic logic [31:0] satInc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Next-state and output logic. Everything visible outside is registered,
    // so this block only computes the values those registers take next.
    always_comb begin
        state_d     = state_q;
        reqLine_d   = reqLine_q;
        reqWdata_d  = reqWdata_q;
        opWrite_d   = opWrite_q;
        opFlush_d   = opFlush_q;
        wasHit_d    = wasHit_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        memReq_d    = memReq_q;
        memWr_d     = memWr_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        hitCount_d  = hitCount_q;
        missCount_d = missCount_q;
        valid_d     = valid_q;
        lineWr      = 1'b0;
        lineWrData  = reqWdata_q;

        case (state_q)
            IDLE: begin
                if (dcache_en) begin
                    reqLine_d  = dcache_addr[63:3];
                    reqWdata_d = dcache_wdata;
                    opFlush_d  = dcache_flush;
                    opWrite_d  = !dcache_flush && dcache_wren;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (opFlush_q) begin
                    if (lookupHit) begin
                        valid_d[lineIdx] = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (opWrite_q) begin
                    // Write-through: memory is always written; the line is
                    // only refreshed later if it already holds this address.
                    wasHit_d   = lookupHit;
                    memReq_d   = 1'b1;
                    memWr_d    = 1'b1;
                    memAddr_d  = {reqLine_q, 3'b000};
                    memWdata_d = reqWdata_q;
                    if (lookupHit) begin
                        hitCount_d = satInc(hitCount_q);
                    end else begin
                        missCount_d = satInc(missCount_q);
                    end
                    state_d = WRITE;
                end else if (lookupHit) begin
                    rdata_d    = dataMem[lineIdx];
                    done_d     = 1'b1;
                    hitCount_d = satInc(hitCount_q);
                    state_d    = IDLE;
                end else begin
                    memReq_d    = 1'b1;
                    memWr_d     = 1'b0;
                    memAddr_d   = {reqLine_q, 3'b000};
                    missCount_d = satInc(missCount_q);
                    state_d     = MISS;
                end
            end
            MISS: begin
                if (mem_ack) begin
                    lineWr           = 1'b1;
                    lineWrData       = mem_rdata;
                    valid_d[lineIdx] = 1'b1;
                    rdata_d          = mem_rdata;
                    done_d           = 1'b1;
                    memReq_d         = 1'b0;
                    state_d          = IDLE;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    lineWr   = wasHit_q;
                    done_d   = 1'b1;
                    memReq_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and status registers; valid bits are cleared on reset so the
    // untouched tag/data arrays can never produce a false hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            reqLine_q   <= '0;
            reqWdata_q  <= '0;
            opWrite_q   <= 1'b0;
            opFlush_q   <= 1'b0;
            wasHit_q    <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            memReq_q    <= 1'b0;
            memWr_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            hitCount_q  <= '0;
            missCount_q <= '0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            reqLine_q   <= reqLine_d;
            reqWdata_q  <= reqWdata_d;
            opWrite_q   <= opWrite_d;
            opFlush_q   <= opFlush_d;
            wasHit_q    <= wasHit_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            memReq_q    <= memReq_d;
            memWr_q     <= memWr_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            hitCount_q  <= hitCount_d;
            missCount_q <= missCount_d;
            valid_q     <= valid_d;
        end
    end

    // Tag and data storage has no reset; an ack landing on a reset edge
    // must not update the line, hence the reset gate on the write.
    always_ff @(posedge clk) begin
        if (lineWr && !reset) begin
            tagMem[lineIdx]  <= lineTag;
            dataMem[lineIdx] <= lineWrData;
        end
    end

    assign dcache_rdata = rdata_q;
    assign dcache_done  = done_q;
    assign mem_req      = memReq_q;
    assign mem_wr       = memWr_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign hit_count    = hitCount_q;
    assign miss_count   = missCount_q;

endmodule
